// File: rtl/vend_timer_pkg.sv
`default_nettype none
// ===========================================================================
// vend_timer_pkg : shared constants, FSM encoding and BCD helper
// Revision 1.0
// ===========================================================================
package vend_timer_pkg;

   localparam int unsigned SEC_MAX_DEFAULT = 99;
   localparam int unsigned BCD_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   // Only valid for v <= 99, which the clamp upstream guarantees.
   function automatic logic [2*BCD_W-1:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_countdown_timer_rise_edge_detect.sv
`default_nettype none
// ===========================================================================
// rise_edge_detect : one-cycle pulse on each rising edge of a same-domain level
// Revision 1.0
// ===========================================================================
module rise_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic r_cur;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur  <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_cur  <= in;
         r_prev <= r_cur;
      end
   end

   assign pulse = r_cur & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/vend_countdown_timer.sv
`default_nettype none
// ===========================================================================
// vend_countdown_timer : two-digit BCD seconds countdown driven by clk1hz ticks
// Revision 1.0
// ===========================================================================
module vend_countdown_timer
   import vend_timer_pkg::*;
#(
   parameter int unsigned SEC_MAX = SEC_MAX_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk1hz,
   input  logic              start,
   input  logic [6:0]        load_sec,
   input  logic              cancel,
   input  logic              pause,
   output logic              tick,
   output logic              running,
   output logic              expired,
   output logic [BCD_W-1:0]  sec_tens,
   output logic [BCD_W-1:0]  sec_ones
);

   state_t            r_state;
   logic [6:0]        w_load_clamped;
   logic [2*BCD_W-1:0] w_load_bcd;
   logic              w_count_is_one;

   rise_edge_detect u_tick_det (
      .clk   (clk),
      .reset (reset),
      .in    (clk1hz),
      .pulse (tick)
   );

   assign w_load_clamped = ({25'd0, load_sec} > SEC_MAX) ? 7'(SEC_MAX) : load_sec;
   assign w_load_bcd     = to_bcd(w_load_clamped);
   assign w_count_is_one = (sec_tens == 4'd0) && (sec_ones == 4'd1);

   // Priority: reset, cancel, start, then tick handling per state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         running  <= 1'b0;
         expired  <= 1'b0;
         sec_tens <= '0;
         sec_ones <= '0;
      end else begin
         expired <= 1'b0;
         if (cancel) begin
            r_state  <= ST_IDLE;
            running  <= 1'b0;
            sec_tens <= '0;
            sec_ones <= '0;
         end else if (start) begin
            if (w_load_clamped == 7'd0) begin
               r_state  <= ST_IDLE;
               running  <= 1'b0;
               expired  <= 1'b1;
               sec_tens <= '0;
               sec_ones <= '0;
            end else begin
               r_state  <= ST_RUN;
               running  <= 1'b1;
               sec_tens <= w_load_bcd[2*BCD_W-1:BCD_W];
               sec_ones <= w_load_bcd[BCD_W-1:0];
            end
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (pause) begin
                     r_state <= ST_PAUSED;
                  end else if (tick) begin
                     if (w_count_is_one) begin
                        r_state  <= ST_IDLE;
                        running  <= 1'b0;
                        expired  <= 1'b1;
                        sec_ones <= '0;
                     end else if (sec_ones == 4'd0) begin
                        sec_tens <= sec_tens - 4'd1;
                        sec_ones <= 4'd9;
                     end else begin
                        sec_ones <= sec_ones - 4'd1;
                     end
                  end
               end
               ST_PAUSED: begin
                  if (!pause) begin
                     r_state <= ST_RUN;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_countdown_timer.sv
`default_nettype none
// ===========================================================================
// tb_vend_countdown_timer : scoreboard bench for vend_countdown_timer
// Revision 1.0
// ===========================================================================
module tb_vend_countdown_timer;

   logic       clk;
   logic       reset;
   logic       clk1hz;
   logic       start;
   logic [6:0] load_sec;
   logic       cancel;
   logic       pause;
   logic       tick;
   logic       running;
   logic       expired;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       tick;
      logic       running;
      logic       expired;
      logic [3:0] tens;
      logic [3:0] ones;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   int   m_state = 0;   // 0 idle, 1 run, 2 paused
   int   m_cnt   = 0;
   logic m_cur   = 1'b0;
   logic m_prev  = 1'b0;
   logic m_exp   = 1'b0;
   logic m_tick  = 1'b0;

   logic hz_en  = 1'b0;
   int   hz_cnt = 0;

   vend_countdown_timer #(.SEC_MAX(99)) dut (
      .clk      (clk),
      .reset    (reset),
      .clk1hz   (clk1hz),
      .start    (start),
      .load_sec (load_sec),
      .cancel   (cancel),
      .pause    (pause),
      .tick     (tick),
      .running  (running),
      .expired  (expired),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // clk1hz stand-in: toggles every 5 cycles, so one rise per 10 cycles
   always @(negedge clk) begin
      if (hz_en) begin
         hz_cnt = hz_cnt + 1;
         if (hz_cnt == 5) begin
            hz_cnt = 0;
            clk1hz = ~clk1hz;
         end
      end
   end

   always @(posedge clk) begin
      logic tk;
      int   v;
      exp_t e;
      tk = m_cur & ~m_prev;
      m_exp = 1'b0;
      if (reset) begin
         m_cur = 0; m_prev = 0; m_state = 0; m_cnt = 0;
      end else begin
         m_prev = m_cur;
         m_cur  = clk1hz;
         if (cancel) begin
            m_state = 0; m_cnt = 0;
         end else if (start) begin
            v = (load_sec > 99) ? 99 : int'(load_sec);
            if (v == 0) begin
               m_state = 0; m_cnt = 0; m_exp = 1'b1;
            end else begin
               m_state = 1; m_cnt = v;
            end
         end else if (m_state == 1) begin
            if (pause) m_state = 2;
            else if (tk) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) begin
                  m_state = 0; m_exp = 1'b1;
               end
            end
         end else if (m_state == 2 && !pause) begin
            m_state = 1;
         end
      end
      m_tick = m_cur & ~m_prev;
      e.tick    = m_tick;
      e.running = (m_state != 0);
      e.expired = m_exp;
      e.tens    = 4'(m_cnt / 10);
      e.ones    = 4'(m_cnt % 10);
      sb.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_tick",    int'(tick),     int'(e.tick));
         chk("sb_running", int'(running),  int'(e.running));
         chk("sb_expired", int'(expired),  int'(e.expired));
         chk("sb_tens",    int'(sec_tens), int'(e.tens));
         chk("sb_ones",    int'(sec_ones), int'(e.ones));
      end
   end

   initial begin
      int   n;
      logic done;
      logic [7:0] prev_d;
      reset = 1; clk1hz = 0; start = 0; load_sec = 0; cancel = 0; pause = 0;
      repeat (3) @(negedge clk);
      chk("rst_running", int'(running), 0);
      chk("rst_expired", int'(expired), 0);
      chk("rst_digits",  int'({sec_tens, sec_ones}), 0);
      chk("rst_tick",    int'(tick), 0);
      reset = 0;
      hz_en = 1;
      repeat (30) @(negedge clk);

      // Load 12 and run to expiry, watching the 10 -> 09 borrow
      start = 1; load_sec = 7'd12;
      @(negedge clk);
      start = 0;
      chk("load12_digits",  int'({sec_tens, sec_ones}), 8'h12);
      chk("load12_running", int'(running), 1);
      done = 0;
      prev_d = {sec_tens, sec_ones};
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (prev_d == 8'h10 && {sec_tens, sec_ones} != 8'h10)
            chk("borrow_10_09", int'({sec_tens, sec_ones}), 8'h09);
         prev_d = {sec_tens, sec_ones};
         if (expired) done = 1;
      end
      chk("exp12_seen",    int'(done), 1);
      chk("exp12_running", int'(running), 0);
      chk("exp12_digits",  int'({sec_tens, sec_ones}), 0);
      @(negedge clk);
      chk("exp12_one_cycle", int'(expired), 0);

      // Clamp, then zero load
      start = 1; load_sec = 7'd120;
      @(negedge clk);
      start = 0;
      chk("clamp_digits", int'({sec_tens, sec_ones}), 8'h99);
      cancel = 1;
      @(negedge clk);
      cancel = 0;
      start = 1; load_sec = 7'd0;
      @(negedge clk);
      start = 0;
      chk("zero_expired", int'(expired), 1);
      chk("zero_running", int'(running), 0);
      @(negedge clk);
      chk("zero_exp_once", int'(expired), 0);

      // Pause across three ticks at 07
      start = 1; load_sec = 7'd7;
      @(negedge clk);
      start = 0; pause = 1;
      n = 0;
      for (int i = 0; i < 200 && n < 3; i++) begin
         @(negedge clk);
         if (m_tick) n++;
      end
      @(negedge clk);
      chk("pause_digits",  int'({sec_tens, sec_ones}), 8'h07);
      chk("pause_running", int'(running), 1);
      pause = 0;
      for (int i = 0; i < 100 && m_cnt == 7; i++) @(negedge clk);
      chk("resume_digits", int'({sec_tens, sec_ones}), 8'h06);

      // Cancel at 05
      for (int i = 0; i < 100 && m_cnt != 5; i++) @(negedge clk);
      cancel = 1;
      @(negedge clk);
      cancel = 0;
      chk("cancel_digits",  int'({sec_tens, sec_ones}), 0);
      chk("cancel_running", int'(running), 0);
      chk("cancel_expired", int'(expired), 0);

      // Start in the same cycle as a tick: tick is dropped
      for (int i = 0; i < 50 && !m_tick; i++) @(negedge clk);
      chk("tick_window_found", int'(m_tick), 1);
      start = 1; load_sec = 7'd3;
      @(negedge clk);
      start = 0;
      chk("start_tick_digits", int'({sec_tens, sec_ones}), 8'h03);

      // Restart mid-count to 05, then reset at 04
      start = 1; load_sec = 7'd5;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 100 && m_cnt != 4; i++) @(negedge clk);
      chk("reached_04", int'({sec_tens, sec_ones}), 8'h04);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("midrst_digits",  int'({sec_tens, sec_ones}), 0);
      chk("midrst_running", int'(running), 0);
      chk("midrst_expired", int'(expired), 0);
      repeat (40) @(negedge clk);
      chk("post_rst_digits",  int'({sec_tens, sec_ones}), 0);
      chk("post_rst_running", int'(running), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
